// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg
//  Shared constants, types and helpers for the RAM-backed stream FIFO.
//  RAM geometry: 4096 x 64, 12-bit addresses. count_t is one bit wider than
//  addr_t so it can represent a completely full RAM (4096) plus the skid words.

package ram_fifo_pkg;

  localparam int unsigned ADDR_WIDTH           = 32'd12;
  localparam int unsigned DATA_WIDTH           = 32'd64;
  localparam int unsigned RAM_DEPTH            = 32'd1 << ADDR_WIDTH;
  localparam int unsigned AFULL_THRESH_DEFAULT = 32'd4064;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH:0]   count_t;

  // Circular pointer advance; the natural 12-bit overflow gives the 4095 -> 0 wrap.
  function automatic addr_t ptr_inc(input addr_t p);
    return p + addr_t'(1);
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if
//  Push/pop stream bundle of the RAM FIFO controller.
//  Signals:
//   in_valid / in_ready / in_data     push stream (producer -> FIFO)
//   out_valid / out_ready / out_data  pop stream  (FIFO -> consumer)
//  Modports:
//   master  the environment: drives in_valid, in_data, out_ready
//   slave   the FIFO: drives in_ready, out_valid, out_data

interface ram_fifo_ctrl_if;
  import ram_fifo_pkg::*;

  logic  in_valid;
  logic  in_ready;
  data_t in_data;
  logic  out_valid;
  logic  out_ready;
  data_t out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/ram_4096.sv
// ram_4096
//  4096 x 64 simple dual-port RAM, one write port and one read port, both
//  synchronous to clk. Read latency is one cycle: data_out shows the addressed
//  word on the cycle after read=1 and holds its value otherwise.
//  Ports: clk, write, wr_address, data_in, read, rd_address, data_out.

module ram_4096
  import ram_fifo_pkg::*;
(
  input  logic  clk,
  input  logic  write,
  input  addr_t wr_address,
  input  data_t data_in,
  input  logic  read,
  input  addr_t rd_address,
  output data_t data_out
);

  data_t mem [RAM_DEPTH];

  // Storage array write port and registered read port.
  always_ff @(posedge clk) begin
    if (write) begin
      mem[wr_address] <= data_in;
    end
    if (read) begin
      data_out <= mem[rd_address];
    end
  end

endmodule

// File: rtl/ram_fifo_skid.sv
// ram_fifo_skid
//  Two-entry in-order output buffer placed behind the RAM read port. It absorbs
//  the one word that may still be in flight from the RAM when the consumer
//  stalls, so out_data never has to wait for a RAM read.
//  Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   load         capture load_data as the newest entry
//   load_data    word returned by the RAM
//   pop          consumer takes the head entry (only when occ > 0)
//   occ[1:0]     number of valid entries, 0..2
//   head_data    oldest entry; held while no pop happens
//  The controller never loads while occ == 2 without a pop.

module ram_fifo_skid
  import ram_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  data_t      load_data,
  input  logic       pop,
  output logic [1:0] occ,
  output data_t      head_data
);

  data_t      entry0;
  data_t      entry1;
  logic [1:0] occ_q;

  // Entry0 is always the head; entry1 only ever holds the second-oldest word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entry0 <= '0;
      entry1 <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({load, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            entry0 <= load_data;
          end else begin
            entry1 <= load_data;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous load and pop: occupancy is unchanged, queue shifts.
          if (occ_q == 2'd1) begin
            entry0 <= load_data;
          end else begin
            entry0 <= entry1;
            entry1 <= load_data;
          end
        end
        default: begin
          occ_q <= occ_q;
        end
      endcase
    end
  end

  assign occ       = occ_q;
  assign head_data = entry0;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//  Stream FIFO controller using an external 4096x64 dual-port RAM (ram_4096)
//  as storage. Push words are written straight into the RAM; the controller
//  prefetches words from the RAM into a 2-entry skid buffer so the RAM's
//  1-cycle read latency is hidden and 1 push + 1 pop per cycle is sustained.
//  Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   fifo (slave)         in_valid/in_ready/in_data push, out_valid/out_ready/out_data pop
//   ram_write, ram_wr_address, ram_data_in   RAM write port
//   ram_read, ram_rd_address, ram_data_out   RAM read port (data one cycle after read)
//   count                total words held: RAM + in-flight read + skid
//   almost_full          RAM occupancy >= AFULL_THRESH
//   drop_cnt[15:0]       only with FIFO_DROP_CNT_EN: saturating count of cycles
//                        with in_valid & !in_ready
//  Optional feature macro: FIFO_DROP_CNT_EN.

module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int unsigned AFULL_THRESH = AFULL_THRESH_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  ram_fifo_ctrl_if.slave fifo,
  output logic        ram_write,
  output addr_t       ram_wr_address,
  output data_t       ram_data_in,
  output logic        ram_read,
  output addr_t       ram_rd_address,
  input  data_t       ram_data_out,
  output count_t      count,
  output logic        almost_full
`ifdef FIFO_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  addr_t      wr_ptr;
  addr_t      rd_ptr;
  count_t     ram_occ;
  count_t     ram_occ_next;
  logic       inflight;
  logic       in_ready_q;
  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] pending;
  logic [1:0] skid_occ;
  data_t      skid_head;

  // Handshakes and prefetch decision. pending counts words already committed
  // to the output side (skid plus the read in flight) after this cycle's pop;
  // a new read is only issued if the skid can still accept its data.
  always_comb begin
    push    = fifo.in_valid & in_ready_q;
    pop     = (skid_occ != 2'd0) & fifo.out_ready;
    pending = {1'b0, skid_occ} + {2'b00, inflight} - {2'b00, pop};
    issue   = (ram_occ != count_t'(0)) && (pending < 3'd2);
  end

  // Next RAM occupancy from this cycle's push and read issue.
  always_comb begin
    ram_occ_next = ram_occ;
    case ({push, issue})
      2'b10:   ram_occ_next = ram_occ + count_t'(1);
      2'b01:   ram_occ_next = ram_occ - count_t'(1);
      default: ram_occ_next = ram_occ;
    endcase
  end

  // Pointers, occupancy, in-flight flag and registered push-ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_occ    <= '0;
      inflight   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr     <= push  ? ptr_inc(wr_ptr) : wr_ptr;
      rd_ptr     <= issue ? ptr_inc(rd_ptr) : rd_ptr;
      ram_occ    <= ram_occ_next;
      inflight   <= issue;
      // Registered from the post-update occupancy so a push can never land
      // in a RAM that is already holding 4096 words.
      in_ready_q <= (ram_occ_next < count_t'(RAM_DEPTH));
    end
  end

`ifdef FIFO_DROP_CNT_EN
  // Saturating count of push attempts refused by the FIFO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_cnt <= 16'h0000;
    end else if (fifo.in_valid && !in_ready_q && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'h0001;
    end else begin
      drop_cnt <= drop_cnt;
    end
  end
`endif

  ram_fifo_skid u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .load      (inflight),
    .load_data (ram_data_out),
    .pop       (pop),
    .occ       (skid_occ),
    .head_data (skid_head)
  );

  // RAM port drive; write data is gated so the bus stays 0 when idle/in reset.
  always_comb begin
    ram_write      = push;
    ram_wr_address = wr_ptr;
    ram_data_in    = push ? fifo.in_data : '0;
    ram_read       = issue;
    ram_rd_address = rd_ptr;
  end

  assign fifo.in_ready  = in_ready_q;
  assign fifo.out_valid = (skid_occ != 2'd0);
  assign fifo.out_data  = skid_head;

  assign count       = ram_occ + count_t'(inflight) + count_t'(skid_occ);
  assign almost_full = (ram_occ >= count_t'(AFULL_THRESH));

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl
//  Bench for ram_fifo_ctrl + ram_4096. A queue-based reference model tracks the
//  words held, RAM occupancy and reads outstanding; every cycle the DUT's
//  handshakes, RAM port and output data are compared against it.

module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  logic   clk = 1'b0;
  logic   resetn;
  logic   ram_write;
  logic   ram_read;
  addr_t  ram_wr_address;
  addr_t  ram_rd_address;
  data_t  ram_data_in;
  data_t  ram_data_out;
  count_t count;
  logic   almost_full;
`ifdef FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  ram_fifo_ctrl_if fif ();

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .fifo           (fif),
    .ram_write      (ram_write),
    .ram_wr_address (ram_wr_address),
    .ram_data_in    (ram_data_in),
    .ram_read       (ram_read),
    .ram_rd_address (ram_rd_address),
    .ram_data_out   (ram_data_out),
    .count          (count),
    .almost_full    (almost_full)
`ifdef FIFO_DROP_CNT_EN
    ,
    .drop_cnt       (drop_cnt)
`endif
  );

  ram_4096 u_ram (
    .clk        (clk),
    .write      (ram_write),
    .wr_address (ram_wr_address),
    .data_in    (ram_data_in),
    .read       (ram_read),
    .rd_address (ram_rd_address),
    .data_out   (ram_data_out)
  );

  // Reference model state
  data_t q[$];
  int    occ_m;
  int    held_m;
  int    wr_m;
  int    rd_m;
  logic  exp_in_ready;
  logic  prev_stall;
  data_t prev_data;
  logic  last_ov;
  data_t last_od;
  int    n_vec;
  int    n_err;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    occ_m        = 0;
    held_m       = 0;
    wr_m         = 0;
    rd_m         = 0;
    exp_in_ready = 1'b0;
    prev_stall   = 1'b0;
    prev_data    = '0;
  endtask

  // One clock cycle: drive just after posedge, check/update on negedge.
  task automatic do_cycle(input logic iv, input data_t id, input logic ordy);
    logic push;
    logic pop;
    logic rd;
    fif.in_valid  = iv;
    fif.in_data   = id;
    fif.out_ready = ordy;
    @(negedge clk);
    push    = iv & fif.in_ready;
    pop     = fif.out_valid & ordy;
    rd      = ram_read;
    last_ov = fif.out_valid;
    last_od = fif.out_data;
    check_eq("in_ready", fif.in_ready, exp_in_ready);
    check_eq("count", count, q.size());
    check_eq("almost_full", almost_full, occ_m >= 4064);
    check_eq("ram_read", rd, (occ_m > 0) && ((held_m - (pop ? 1 : 0)) < 2));
    if (rd) check_eq("rd_addr", ram_rd_address, rd_m % 4096);
    check_eq("ram_write", ram_write, push);
    if (push) begin
      check_eq("wr_addr", ram_wr_address, wr_m % 4096);
      check_eq("wr_data", ram_data_in, id);
    end
    if (q.size() == 0) check_eq("empty_ov", fif.out_valid, 1'b0);
    else if (fif.out_valid) check_eq("out_data", fif.out_data, q[0]);
    if (prev_stall) begin
      check_eq("stall_ov", fif.out_valid, 1'b1);
      check_eq("stall_data", fif.out_data, prev_data);
    end
    if (push) begin
      q.push_back(id);
      wr_m++;
      occ_m++;
    end
    if (rd) begin
      rd_m++;
      occ_m--;
      held_m++;
    end
    if (pop && q.size() > 0) begin
      void'(q.pop_front());
      held_m--;
    end
    exp_in_ready = (occ_m < 4096);
    prev_stall   = fif.out_valid & ~ordy;
    prev_data    = fif.out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cyc);
    fif.in_valid  = 1'b1;
    fif.in_data   = '1;
    fif.out_ready = 1'b1;
    resetn = 1'b0;
    #1;
    check_eq("rst_in_ready", fif.in_ready, 1'b0);
    check_eq("rst_out_valid", fif.out_valid, 1'b0);
    check_eq("rst_ram_write", ram_write, 1'b0);
    check_eq("rst_ram_read", ram_read, 1'b0);
    check_eq("rst_count", count, 0);
    check_eq("rst_afull", almost_full, 1'b0);
    check_eq("rst_wr_addr", ram_wr_address, 0);
    check_eq("rst_rd_addr", ram_rd_address, 0);
    check_eq("rst_data_in", ram_data_in, 0);
    check_eq("rst_out_data", fif.out_data, 0);
    repeat (cyc) @(posedge clk);
    #1;
    check_eq("rst_hold_in_ready", fif.in_ready, 1'b0);
    check_eq("rst_hold_count", count, 0);
    fif.in_valid  = 1'b0;
    fif.out_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    exp_in_ready = 1'b1;
    check_eq("rel_in_ready", fif.in_ready, 1'b1);
  endtask

  // Push words base+k (k = current fill level) with consumer stalled.
  task automatic fill_to(input int target, input data_t base);
    int guard = 0;
    while (q.size() < target && guard < 20000) begin
      do_cycle(fif.in_ready, base + data_t'(q.size()), 1'b0);
      guard++;
    end
    check_eq("fill_level", q.size(), target);
  endtask

  task automatic drain_all(input logic no_gap);
    int   guard   = 0;
    logic started = 1'b0;
    while (q.size() > 0 && guard < 10000) begin
      if (no_gap && started) check_eq("no_gap", fif.out_valid, 1'b1);
      if (fif.out_valid) started = 1'b1;
      do_cycle(1'b0, '0, 1'b1);
      guard++;
    end
    check_eq("drained", q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    model_clear();
    resetn        = 1'b1;
    fif.in_valid  = 1'b0;
    fif.in_data   = '0;
    fif.out_ready = 1'b0;
    #2;

    // 1. Reset
    do_reset(3);

    // 2. Latency through an empty FIFO
    do_cycle(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1);
    do_cycle(1'b0, '0, 1'b1);
    check_eq("lat_c1_ov", last_ov, 1'b0);
    do_cycle(1'b0, '0, 1'b1);
    check_eq("lat_c2_ov", last_ov, 1'b0);
    do_cycle(1'b0, '0, 1'b1);
    check_eq("lat_c3_ov", last_ov, 1'b1);
    check_eq("lat_c3_data", last_od, 64'hDEAD_BEEF_0000_0001);
    do_cycle(1'b0, '0, 1'b1);
    check_eq("lat_count0", count, 0);

    // 3. Fill to 4098, then drain in order without gaps
    fill_to(4098, 64'd0);
    repeat (3) do_cycle(1'b0, '0, 1'b0);
    check_eq("full_count", count, 4098);
    check_eq("full_in_ready", fif.in_ready, 1'b0);
    check_eq("full_afull", almost_full, 1'b1);
    for (int k = 0; k < 4098; k++) begin
      if (q.size() > k) check_eq("full_order", q[k], k);
    end
    drain_all(1'b1);

    // 4. Streaming push-1/pop-1 across pointer wraps
    begin
      int start_wr = wr_m;
      int guard    = 0;
      while ((wr_m - start_wr) < 10000 && guard < 12000) begin
        do_cycle(1'b1, {$urandom, $urandom}, 1'b1);
        check_eq("wrap_cnt_le3", count <= 13'd3, 1'b1);
        guard++;
      end
      check_eq("wrap_pushed", wr_m - start_wr, 10000);
      check_eq("wrap_twice", wr_m >= 2 * 4096, 1'b1);
      drain_all(1'b0);
    end

    // 5. Random stalls on both sides
    for (int c = 0; c < 3000; c++) begin
      do_cycle(($urandom % 10) < 7, {$urandom, $urandom}, $urandom % 2);
    end
    drain_all(1'b0);

    // 6. Mid-operation reset, then first word out after reset
    fill_to(100, 64'h1000);
    check_eq("pre_rst_count", count, 100);
    do_reset(3);
    do_cycle(1'b1, 64'h5A5A, 1'b0);
    do_cycle(1'b1, {$urandom, $urandom}, 1'b0);
    do_cycle(1'b1, {$urandom, $urandom}, 1'b0);
    begin
      int guard = 0;
      while (!fif.out_valid && guard < 10) begin
        do_cycle(1'b0, '0, 1'b0);
        guard++;
      end
      check_eq("post_rst_ov", fif.out_valid, 1'b1);
      check_eq("post_rst_first", fif.out_data, 64'h5A5A);
    end
    drain_all(1'b0);

    // Pushes while full are refused and leave contents intact
    fill_to(4098, 64'h2000);
    repeat (5) do_cycle(1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
    check_eq("full_hold_count", count, 4098);
`ifdef FIFO_DROP_CNT_EN
    check_eq("drop_cnt", drop_cnt, 16'd5);
`endif
    drain_all(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
